param_cacheline_adaptor: RTL

Parametrised successor to the fixed 256b/64b line adaptor between the LLC and burst memory. It converts one LLC line request into BEATS = LINE_WIDTH/BURST_WIDTH memory beats, and back. Line width, burst width, and address width are generic. It adds line-aligned address output, registered request capture, deterministic read/write priority, and an optional memory timeout.

---
 rtl/param_cacheline_adaptor_pkg.sv | 33 +++
 rtl/param_cacheline_adaptor_counter.sv | 38 +++
 rtl/param_cacheline_adaptor.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/param_cacheline_adaptor_pkg.sv
// Shared types, default widths and width helpers for the line adaptor.
// Feature macro PARAM_CACHELINE_ADAPTOR_TIMEOUT_EN enables the memory watchdog.
package param_cacheline_adaptor_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  localparam int DEF_LINE_WIDTH     = 256;
  localparam int DEF_BURST_WIDTH    = 64;
  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

  function automatic int beats_f(input int lw, input int bw);
    return lw / bw;
  endfunction

  function automatic int off_bits_f(input int lw);
    return $clog2(lw / 8);
  endfunction

  // Beat count must be a power of two of at least two, beats byte sized
  function automatic bit ratio_ok_f(input int lw, input int bw);
    int b;
    if (bw <= 0 || (bw % 8) != 0 || (lw % bw) != 0) return 1'b0;
    b = lw / bw;
    return (b >= 2) && ((b & (b - 1)) == 0);
  endfunction

endpackage

// File: rtl/param_cacheline_adaptor_counter.sv
// Wrapping up-counter with enable, clear and terminal-count flag.
// Used for beat indexing and for the memory watchdog.
module burst_beat_counter #(
  parameter int MAX = 4,
  parameter int W   = (MAX > 1) ? $clog2(MAX) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign tc_o  = (cnt_q == W'(MAX - 1));
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_cacheline_adaptor.sv
// LLC line <-> memory burst adaptor, generic widths.
// Define PARAM_CACHELINE_ADAPTOR_TIMEOUT_EN to add the resp_i watchdog.
module param_cacheline_adaptor
  import param_cacheline_adaptor_pkg::*;
#(
  parameter int LINE_WIDTH     = DEF_LINE_WIDTH,
  parameter int BURST_WIDTH    = DEF_BURST_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  output logic                   err_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);

  localparam int BEATS = beats_f(LINE_WIDTH, BURST_WIDTH);
  localparam int CW    = $clog2(BEATS);
  localparam int OFF   = off_bits_f(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ~ADDR_WIDTH'((1 << OFF) - 1);

  if (!ratio_ok_f(LINE_WIDTH, BURST_WIDTH) || TIMEOUT_CYCLES < 1)
  begin : g_bad_cfg
    $error("param_cacheline_adaptor: illegal width configuration");
  end

  state_e                  state_q, state_d;
  logic [LINE_WIDTH-1:0]   buf_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    resp_q;
  logic                    rd_q;
  logic                    to_q;
  logic [CW-1:0]           cnt;
  logic                    cnt_tc;
  logic                    busy;
  logic                    beat;
  logic                    accept;
  logic                    timeout;

  assign busy   = (state_q == READ) || (state_q == WRITE);
  assign beat   = busy && resp_i;
  // resp_q blocks re-acceptance while the LLC still holds its request
  assign accept = (state_q == IDLE) && !resp_q && (read_i || write_i);

  burst_beat_counter #(
    .MAX (BEATS),
    .W   (CW)
  ) u_beat_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (beat),
    .clr_i   (timeout),
    .cnt_o   (cnt),
    .tc_o    (cnt_tc)
  );

`ifdef PARAM_CACHELINE_ADAPTOR_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WW-1:0] wd_cnt;
  logic          wd_tc;
  logic          err_q;

  burst_beat_counter #(
    .MAX (TIMEOUT_CYCLES),
    .W   (WW)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (busy && !resp_i),
    .clr_i   (!busy || resp_i),
    .cnt_o   (wd_cnt),
    .tc_o    (wd_tc)
  );

  assign timeout = busy && !resp_i && wd_tc;
  assign err_o   = err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= (state_q == DONE) && to_q;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = read_i ? READ : WRITE;
      end
      READ, WRITE: begin
        if (timeout || (resp_i && cnt_tc)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      resp_q  <= (state_q == DONE);
      if (accept) begin
        addr_q <= address_i & AMASK;
        rd_q   <= read_i;
        if (!read_i) buf_q <= line_i;
      end
      if (busy) to_q <= timeout;
      if (beat && state_q == READ) begin
        buf_q[int'(cnt)*BURST_WIDTH +: BURST_WIDTH] <= burst_i;
      end
      if (state_q == DONE && rd_q && !to_q) line_q <= buf_q;
    end
  end

  assign line_o    = line_q;
  assign address_o = addr_q;
  assign resp_o    = resp_q;
  assign read_o    = (state_q == READ);
  assign write_o   = (state_q == WRITE);
  assign burst_o   = (state_q == WRITE)
                   ? buf_q[int'(cnt)*BURST_WIDTH +: BURST_WIDTH]
                   : '0;

endmodule
